nibble_unload_fsm: RTL and testbench
====================================

NIBBLE_UNLOAD_FSM -- requirements
Module: nibble_unload_fsm

Interface
REQ-001 The parameter TICK_MAX SHALL default to 150000000 and set the number of clk cycles per emission tick; legal values are 2 or greater.
REQ-002 The port clk SHALL be an input, 1 bit wide, and serve as the single system clock; all state SHALL update on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, with asynchronous, active-high reset.
REQ-004 The port load SHALL be an input, 1 bit wide; an active-high single-cycle pulse requests a parallel load of din.
REQ-005 The port din SHALL be an input, 16 bits wide, carrying four nibbles; din[15:12] is emitted first.
REQ-006 The port button SHALL be an asynchronous, active-low input, 1 bit wide; a low level permits emission.
REQ-007 The port out SHALL be an output, 4 bits wide, holding the most recently emitted nibble.
REQ-008 The port strobe SHALL be an output, 1 bit wide, asserted high for exactly one cycle in the cycle out updates.
REQ-009 The port remaining SHALL be an output, 3 bits wide, giving the number of nibbles not yet emitted (0-4).
REQ-010 The port empty SHALL be an output, 1 bit wide, and be high when remaining equals 0.
REQ-011 The port hex5 SHALL be an output, 7 bits wide, driving an active-low 7-segment display of out, with bit0 for segment a through bit6 for segment g.

Function
REQ-012 The block SHALL pass button through a 2-flop synchronizer; only the synchronized value (btn_s) SHALL affect behaviour.
REQ-013 The tick counter SHALL count from 0 to TICK_MAX-1 and then wrap to 0, generating a one-cycle tick when the count equals TICK_MAX-1.
REQ-014 An accepted load SHALL clear the tick counter, so the first tick after a load falls exactly TICK_MAX cycles after the load cycle.
REQ-015 The FSM SHALL have three states: IDLE, ARMED and DONE.
REQ-016 In IDLE or DONE, load=1 SHALL capture din into the shift register and the saved word, set remaining to 4, and move to ARMED; out SHALL be unchanged.
REQ-017 In ARMED, when tick=1 and btn_s=0, the block SHALL set out to sreg[15:12], shift sreg left by 4, decrement remaining and pulse strobe.
REQ-018 In ARMED, an emission that takes remaining from 1 to 0 SHALL move the FSM to DONE.
REQ-019 In ARMED, when tick=1 and btn_s=1, the block SHALL skip the emission; the tick is lost and state is unchanged.
REQ-020 In ARMED, load=1 SHALL reload din, set remaining to 4, restart the tick counter and produce no emission, even if tick=1 in the same cycle (load wins).
REQ-021 In IDLE and DONE, ticks SHALL be ignored and strobe SHALL stay 0.
REQ-022 hex5 SHALL be a combinational decode of out covering 0-F (hex digits 0-9, A, b, C, d, E, F).

Reset
REQ-023 While rst=1, the block SHALL force the FSM to IDLE, out=0, strobe=0, remaining=0, empty=1, sreg=0, saved word=0, tick counter=0 and synchronizer flops=1 (released).
REQ-024 While rst=1, hex5 SHALL show 7'b1000000 ("0"), and assertion of rst mid-operation SHALL abort immediately without any further strobe.

Configuration
REQ-025 When UNLOAD_WRAP_EN is defined, an emission in ARMED that takes remaining to 0 SHALL instead reload sreg from the saved word, set remaining to 4 and stay in ARMED, so DONE is never entered and empty never rises after a load.
REQ-026 When UNLOAD_WRAP_EN is undefined, the behaviour SHALL follow REQ-018.

Verification (TICK_MAX=4)
REQ-027 The bench SHALL apply reset, then load din=16'h1234 with button held low, and SHALL check strobe pulses at 4, 8, 12 and 16 cycles after the load, out=1, 2, 3, 4 in turn, remaining=3, 2, 1, 0, and finally empty=1 with the FSM in DONE.
REQ-028 The bench SHALL hold button high through two ticks after a load, and SHALL check no strobe occurs and remaining stays 4, then release the button and check out=1 on the next tick.
REQ-029 The bench SHALL assert load with din=16'hABCD in the same cycle as a tick after two emissions of 16'h1234, and SHALL check no strobe, remaining=4, and a next emission out=A four cycles later.
REQ-030 The bench SHALL assert rst asynchronously (between clock edges) after one emission, and SHALL check out=0, remaining=0, empty=1 and hex5=7'b1000000 immediately, with no strobe after release.
REQ-031 With UNLOAD_WRAP_EN defined, the bench SHALL load 16'h5A0F and SHALL check eight emissions 5, A, 0, F, 5, A, 0, F with empty staying 0 throughout.
REQ-032 The bench SHALL sweep out through 0-F and check hex5 against the decode table, including out=8 giving hex5=7'b0000000.

Source files
------------

// File: rtl/nibble_unload_fsm.sv
// nibble_unload_fsm
// Loads a 16-bit word and emits it one nibble per tick, most significant
// nibble first, while the (active-low) button is held down.
//
// Optional feature: define UNLOAD_WRAP_EN to make the last emission reload
// the saved word so that the word repeats forever instead of ending in DONE.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   load       single-cycle pulse, captures din
//   din[15:0]  word to emit, din[15:12] first
//   button     asynchronous active-low emission enable
//   out[3:0]   most recently emitted nibble
//   strobe     one-cycle pulse in the cycle out updates
//   remaining  nibbles not yet emitted (0-4)
//   empty      remaining == 0
//   hex5[6:0]  active-low 7-segment decode of out (bit0 = a .. bit6 = g)
module nibble_unload_fsm #(
  parameter int TICK_MAX = 150000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        button,
  output logic [3:0]  out,
  output logic        strobe,
  output logic [2:0]  remaining,
  output logic        empty,
  output logic [6:0]  hex5
);

  localparam int CW = $clog2(TICK_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state, state_n;
  logic           btn_q1, btn_s;
  logic [CW-1:0]  cnt;
  logic           tick;
  logic [15:0]    sreg, sreg_n;
  logic [15:0]    saved, saved_n;
  logic [3:0]     out_n;
  logic [2:0]     rem_n;
  logic           strobe_n;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q1 <= 1'b1;
      btn_s  <= 1'b1;
    end else begin
      btn_q1 <= button;
      btn_s  <= btn_q1;
    end
  end

  // Tick counter. Any load restarts it so the first tick lands exactly
  // TICK_MAX cycles after the load cycle.
  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // Next-state and datapath decode.
  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    saved_n  = saved;
    out_n    = out;
    rem_n    = remaining;
    strobe_n = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (load) begin
          sreg_n  = din;
          saved_n = din;
          rem_n   = 3'd4;
          state_n = ARMED;
        end
      end
      ARMED: begin
        // Load takes priority over a coincident tick.
        if (load) begin
          sreg_n  = din;
          saved_n = din;
          rem_n   = 3'd4;
        end else if (tick && !btn_s) begin
          out_n    = sreg[15:12];
          sreg_n   = {sreg[11:0], 4'h0};
          rem_n    = remaining - 3'd1;
          strobe_n = 1'b1;
          if (remaining == 3'd1) begin
`ifdef UNLOAD_WRAP_EN
            sreg_n = saved;
            rem_n  = 3'd4;
`else
            state_n = DONE;
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      saved     <= '0;
      out       <= '0;
      remaining <= '0;
      strobe    <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      saved     <= saved_n;
      out       <= out_n;
      remaining <= rem_n;
      strobe    <= strobe_n;
    end
  end

  assign empty = (remaining == 3'd0);

  // Active-low segments, {g,f,e,d,c,b,a}.
  always_comb begin
    hex5 = 7'b1111111;
    case (out)
      4'h0: hex5 = 7'b1000000;
      4'h1: hex5 = 7'b1111001;
      4'h2: hex5 = 7'b0100100;
      4'h3: hex5 = 7'b0110000;
      4'h4: hex5 = 7'b0011001;
      4'h5: hex5 = 7'b0010010;
      4'h6: hex5 = 7'b0000010;
      4'h7: hex5 = 7'b1111000;
      4'h8: hex5 = 7'b0000000;
      4'h9: hex5 = 7'b0010000;
      4'hA: hex5 = 7'b0001000;
      4'hB: hex5 = 7'b0000011;
      4'hC: hex5 = 7'b1000110;
      4'hD: hex5 = 7'b0100001;
      4'hE: hex5 = 7'b0000110;
      4'hF: hex5 = 7'b0001110;
      default: hex5 = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_nibble_unload_fsm.sv
// Testbench for nibble_unload_fsm with TICK_MAX = 4. Expected emissions are
// queued when a load is driven and popped when strobe appears.
module tb_nibble_unload_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] din = '0;
  logic        button = 1'b0;
  logic [3:0]  out;
  logic        strobe;
  logic [2:0]  remaining;
  logic        empty;
  logic [6:0]  hex5;

  nibble_unload_fsm #(.TICK_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (din),
    .button    (button),
    .out       (out),
    .strobe    (strobe),
    .remaining (remaining),
    .empty     (empty),
    .hex5      (hex5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] hex;
  } vec_t;
  vec_t vec[16];

  typedef struct {
    logic [3:0] out;
    logic [2:0] rem;
    logic [6:0] hex;
    int         cyc;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] rem_after(input int k);
`ifdef UNLOAD_WRAP_EN
    return (k == 3) ? 3'd4 : 3'(3 - k);
`else
    return 3'(3 - k);
`endif
  endfunction

  // Queue `count` emissions of word d loaded at cycle lc, the first `skip`
  // ticks being suppressed by the button.
  task automatic push(input logic [15:0] d, input int lc, input int skip, input int count);
    for (int k = 0; k < count; k++) begin
      exp_t e;
      logic [3:0] n;
      n = d[15 - 4*(k % 4) -: 4];
      e.out = n;
      e.rem = rem_after(k % 4);
      e.hex = vec[n].hex;
      e.cyc = lc + 4*(k + 1 + skip);
      q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the load edge.
  task automatic do_load(input logic [15:0] d, output int lc);
    din  = d;
    load = 1'b1;
    lc   = cyc + 1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  // Strobe monitor / scoreboard.
  always @(negedge clk) begin
    if (strobe) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: strobe=1 at cycle %0d, expected 0", cyc);
      end else begin
        mon_e = q.pop_front();
        check("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("out", 32'(out), 32'(mon_e.out));
        check("remaining", 32'(remaining), 32'(mon_e.rem));
        check("empty", 32'(empty), 32'(mon_e.rem == 3'd0));
        check("hex5", 32'(hex5), 32'(mon_e.hex));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [6:0] seg [16];
    logic [15:0] d;
    int lc, lc2;
    seg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    for (int i = 0; i < 16; i++) begin
      vec[i].nib = 4'(i);
      vec[i].hex = seg[i];
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_strobe", 32'(strobe), 32'd0);
    check("rst_hex5", 32'(hex5), 32'h40);
    check("rst_state", 32'(dut.state), 32'd0);
    check("rst_sync", 32'(dut.btn_s), 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

`ifndef UNLOAD_WRAP_EN
    // Full unload of 1234
    do_load(16'h1234, lc);
    push(16'h1234, lc, 0, 4);
    check("load_remaining", 32'(remaining), 32'd4);
    drain(30);
    repeat (6) @(negedge clk);
    check("done_empty", 32'(empty), 32'd1);
    check("done_remaining", 32'(remaining), 32'd0);
    check("done_state", 32'(dut.state), 32'd2);

    // Button held high through two ticks
    button = 1'b1;
    repeat (4) @(negedge clk);
    do_load(16'h1234, lc);
    wait_cyc(lc + 9);
    check("skip_remaining", 32'(remaining), 32'd4);
    button = 1'b0;
    push(16'h1234, lc, 2, 4);
    drain(40);

    // Load coinciding with a tick after two emissions
    do_load(16'h1234, lc);
    push(16'h1234, lc, 0, 2);
    wait_cyc(lc + 11);
    do_load(16'hABCD, lc2);
    check("load_wins_remaining", 32'(remaining), 32'd4);
    check("load_wins_out", 32'(out), 32'h2);
    push(16'hABCD, lc2, 0, 4);
    drain(40);
`else
    // Wrap: word repeats, empty never rises
    do_load(16'h5A0F, lc);
    push(16'h5A0F, lc, 0, 8);
    drain(60);
    check("wrap_empty", 32'(empty), 32'd0);
`endif

    // Asynchronous reset mid-operation
    do_load(16'h1234, lc);
    push(16'h1234, lc, 0, 1);
    wait_cyc(lc + 6);
    #2 rst = 1'b1;
    #1;
    check("arst_out", 32'(out), 32'd0);
    check("arst_remaining", 32'(remaining), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_hex5", 32'(hex5), 32'h40);
    check("arst_strobe", 32'(strobe), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("arst_queue", 32'(q.size()), 32'd0);

    // hex5 sweep over all nibble values
    for (int w = 0; w < 4; w++) begin
      d = {vec[4*w].nib, vec[4*w+1].nib, vec[4*w+2].nib, vec[4*w+3].nib};
      do_load(d, lc);
      push(d, lc, 0, 4);
      drain(30);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
